seq_mult: RTL and testbench

- Parametrised, registered, sequential shift-add multiplier.
- Successor to the fixed 2-bit times-3 registered multiplier. It takes two WIDTH-bit operands and produces a 2*WIDTH-bit product in WIDTH clock cycles.
- Uses a start/busy/done handshake and has an optional signed mode.
- Sits as a reusable arithmetic unit behind simple control logic in the prelim designs.

---
 rtl/seq_mult_pkg.sv | 22 ++
 rtl/seq_mult_if.sv | 14 +
 rtl/seq_mult.sv | 109 ++++++++++
 tb/tb_seq_mult.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// counter sizing and operand magnitude helper.
package seq_mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAX_W = 16;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Magnitude of a sign-extended operand; the most negative value maps to
  // 2^(W-1), which still fits once truncated back to W unsigned bits.
  function automatic logic [MAX_W-1:0] abs_val(input logic signed [MAX_W-1:0] v);
    return v[MAX_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Start/busy/done handshake and operand/result bus of the sequential multiplier.
interface seq_mult_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult.sv
// Registered shift-add multiplier: WIDTH cycles per product, optional
// two's-complement mode via sign/magnitude operand preparation.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_mult_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PW-1:0]      product_q, product_d;

  logic signed [MAX_W-1:0] a_sx, b_sx;
  logic [WIDTH-1:0]        a_mag, b_mag;
  logic                    neg_in;
  logic [PW-1:0]           acc_nxt;

  always_comb begin
    a_sx   = MAX_W'(signed'(bus.a));
    b_sx   = MAX_W'(signed'(bus.b));
    a_mag  = SIGNED_EN ? WIDTH'(abs_val(a_sx)) : bus.a;
    b_mag  = SIGNED_EN ? WIDTH'(abs_val(b_sx)) : bus.b;
    neg_in = SIGNED_EN && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
          neg_d    = neg_in;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        // Last bit consumed: publish the signed-corrected sum this edge.
        if (cnt_q == CNT_W'(1)) begin
          product_d = neg_q ? -acc_nxt : acc_nxt;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: 4-bit unsigned, 4-bit signed and 8-bit
// unsigned instances share one stimulus path selected by sel.
module tb_seq_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_drv = 1'b0;
  logic [15:0] a_drv = '0;
  logic [15:0] b_drv = '0;
  int          sel = 0;

  logic        obs_busy, obs_done;
  logic [15:0] obs_prod;

  logic [15:0] sb[$];
  int n_checks = 0;
  int n_errors = 0;

  seq_mult_if #(.WIDTH(4)) if_u4 ();
  seq_mult_if #(.WIDTH(4)) if_s4 ();
  seq_mult_if #(.WIDTH(8)) if_u8 ();

  assign if_u4.start = start_drv && (sel == 0);
  assign if_u4.a     = a_drv[3:0];
  assign if_u4.b     = b_drv[3:0];
  assign if_s4.start = start_drv && (sel == 1);
  assign if_s4.a     = a_drv[3:0];
  assign if_s4.b     = b_drv[3:0];
  assign if_u8.start = start_drv && (sel == 2);
  assign if_u8.a     = a_drv[7:0];
  assign if_u8.b     = b_drv[7:0];

  seq_mult #(.WIDTH(4), .SIGNED_EN(1'b0)) dut_u4 (.clk(clk), .rst_n(rst_n), .bus(if_u4.slave));
  seq_mult #(.WIDTH(4), .SIGNED_EN(1'b1)) dut_s4 (.clk(clk), .rst_n(rst_n), .bus(if_s4.slave));
  seq_mult #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_u8 (.clk(clk), .rst_n(rst_n), .bus(if_u8.slave));

  always_comb begin
    obs_busy = if_u4.busy;
    obs_done = if_u4.done;
    obs_prod = {8'h00, if_u4.product};
    case (sel)
      1: begin
        obs_busy = if_s4.busy;
        obs_done = if_s4.done;
        obs_prod = {8'h00, if_s4.product};
      end
      2: begin
        obs_busy = if_u8.busy;
        obs_done = if_u8.done;
        obs_prod = if_u8.product;
      end
      default: ;
    endcase
  end

  function automatic logic [15:0] model(input int s, input logic [15:0] av, input logic [15:0] bv);
    int x, y;
    case (s)
      0: begin x = av[3:0]; y = bv[3:0]; return 16'(x * y) & 16'h00FF; end
      1: begin x = $signed(av[3:0]); y = $signed(bv[3:0]); return 16'(x * y) & 16'h00FF; end
      default: begin x = av[7:0]; y = bv[7:0]; return 16'(x * y); end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv);
    start_drv = 1'b1;
    a_drv = av;
    b_drv = bv;
    sb.push_back(model(sel, av, bv));
    @(negedge clk);
    start_drv = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat);
    int n = 0;
    int busy_low = 0;
    logic [15:0] exp;
    while (obs_done !== 1'b1 && n < 40) begin
      if (obs_busy !== 1'b1) busy_low++;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, lat);
    end
    n_checks++;
    if (busy_low !== 0) begin
      n_errors++;
      $display("FAIL %s busy_held: busy low in %0d run cycles, expected 0", name, busy_low);
    end
    n_checks++;
    if (obs_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, obs_busy);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
    n_checks++;
    if (obs_prod !== exp) begin
      n_errors++;
      $display("FAIL %s product: got %h expected %h", name, obs_prod, exp);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({if_u4.busy, if_u4.done, if_u4.product} !== 10'h0) begin
      n_errors++;
      $display("FAIL reset_u4: got %h expected 000", {if_u4.busy, if_u4.done, if_u4.product});
    end
    n_checks++;
    if ({if_s4.busy, if_s4.done, if_s4.product} !== 10'h0) begin
      n_errors++;
      $display("FAIL reset_s4: got %h expected 000", {if_s4.busy, if_s4.done, if_s4.product});
    end
    n_checks++;
    if ({if_u8.busy, if_u8.done, if_u8.product} !== 18'h0) begin
      n_errors++;
      $display("FAIL reset_u8: got %h expected 00000", {if_u8.busy, if_u8.done, if_u8.product});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", obs_busy, obs_done);
    end
  endtask

  task automatic test_unsigned();
    sel = 0;
    issue(16'd3, 16'd3);
    wait_done("u4_3x3", 4);
    @(negedge clk);
    n_checks++;
    if (obs_done !== 1'b0) begin
      n_errors++;
      $display("FAIL done_pulse_width: got %b expected 0", obs_done);
    end
    n_checks++;
    if (obs_prod !== 16'h0009) begin
      n_errors++;
      $display("FAIL product_hold: got %h expected 0009", obs_prod);
    end
    issue(16'd15, 16'd15);
    wait_done("u4_15x15", 4);
    issue(16'd0, 16'd9);
    wait_done("u4_0x9", 4);
  endtask

  task automatic test_back_to_back();
    issue(16'd3, 16'd1);
    n_checks++;
    if (obs_done !== 1'b0 || obs_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", obs_busy, obs_done);
    end
    wait_done("u4_b2b_3x1", 4);
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    issue(16'd2, 16'd3);
    @(negedge clk);
    start_drv = 1'b1;
    a_drv = 16'd7;
    b_drv = 16'd7;
    @(negedge clk);
    start_drv = 1'b0;
    wait_done("u4_ignored_start", 2);
    @(negedge clk);
    n_checks++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_reextend: busy=%b done=%b expected 0 0", obs_busy, obs_done);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    issue(16'd5, 16'd5);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_prod !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h expected 0 0 0000",
               obs_busy, obs_done, obs_prod);
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (obs_done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_errors++;
      $display("FAIL aborted_done: got %0d done pulses expected 0", dones);
    end
    issue(16'd5, 16'd5);
    wait_done("u4_after_abort", 4);
  endtask

  task automatic test_signed();
    logic [15:0] va[4] = '{16'hD, 16'h8, 16'h8, 16'h7};
    logic [15:0] vb[4] = '{16'h2, 16'h8, 16'h7, 16'hF};
    sel = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i]);
      wait_done($sformatf("s4_vec%0d", i), 4);
    end
    for (int i = 0; i < 20; i++) begin
      issue(16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)));
      wait_done($sformatf("s4_rand%0d", i), 4);
    end
    @(negedge clk);
  endtask

  task automatic test_wide();
    sel = 2;
    @(negedge clk);
    issue(16'hFF, 16'hFF);
    wait_done("u8_ffxff", 8);
    for (int i = 0; i < 200; i++) begin
      issue(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
      wait_done($sformatf("u8_rand%0d", i), 8);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_unsigned();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_signed();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
